fejkon_pcie_tx_arb: RTL and testbench

Packet-granular arbiter that shares the single 256-bit PCIe hard-IP TX Avalon-ST interface (tx_st) between two sources: the completion generator (cpl_*, CplD for inbound MRd) and the DMA write path (dma_*, MWr built from data_tx).
Completions have priority, bounded by a starvation limit so DMA always progresses.
The output is registered through a 2-entry skid buffer, so tx_st_* is driven directly from flops.

---
 rtl/fejkon_pcie_pkg.sv | 37 +++
 rtl/fejkon_st_skid2.sv | 76 +++++++
 rtl/fejkon_pcie_tx_arb.sv | 192 +++++++++++++++++++
 tb/tb_fejkon_pcie_tx_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fejkon_pcie_pkg.sv
// Shared types for the fejkon PCIe TLP datapath: grant encoding and the
// Avalon-ST beat layout carried through the TX/RX pipeline registers.
package fejkon_pcie_pkg;

    localparam int TLP_DATA_W  = 256;
    localparam int TLP_EMPTY_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_CPL  = 2'b01,
        ARB_DMA  = 2'b10
    } arb_grant_e;

    typedef struct packed {
        logic [TLP_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [TLP_EMPTY_W-1:0] empty;
    } tlp_beat_t;

    localparam int TLP_BEAT_W = $bits(tlp_beat_t);

    function automatic tlp_beat_t make_beat(
        input logic [TLP_DATA_W-1:0]  data,
        input logic                   sop,
        input logic                   eop,
        input logic [TLP_EMPTY_W-1:0] empty
    );
        tlp_beat_t b;
        b.data  = data;
        b.sop   = sop;
        b.eop   = eop;
        b.empty = empty;
        return b;
    endfunction

endpackage

// File: rtl/fejkon_st_skid2.sv
// Two-entry Avalon-ST pipeline register: outputs come straight from flops and
// the sink sees ready from registered state only, so neither side has a comb path.
module fejkon_st_skid2
    import fejkon_pcie_pkg::*;
#(
    parameter int W = TLP_BEAT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         head_vld_q, head_vld_d;
    logic         tail_vld_q, tail_vld_d;
    logic         push;
    logic         pop;

    assign in_ready  = ~tail_vld_q;
    assign out_valid = head_vld_q;
    assign out_data  = head_q;

    assign push = in_valid & ~tail_vld_q;
    assign pop  = head_vld_q & out_ready;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        if (pop) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_vld_d = 1'b0;
            end else if (push) begin
                head_d = in_data;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_d     = in_data;
                head_vld_d = 1'b1;
            end else begin
                tail_d     = in_data;
                tail_vld_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

    // NOTE: the tail payload is not reset; it is never observable while tail_vld_q is low.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

endmodule

// File: rtl/fejkon_pcie_tx_arb.sv
// Packet-granular arbiter sharing the hard-IP TX stream between the completion
// generator and the DMA write path; completions win, bounded by a burst limit.
module fejkon_pcie_tx_arb
    import fejkon_pcie_pkg::*;
#(
    parameter int CPL_BURST_MAX = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [255:0]     cpl_data,
    input  logic             cpl_startofpacket,
    input  logic             cpl_endofpacket,
    input  logic [1:0]       cpl_empty,
    input  logic             cpl_valid,
    output logic             cpl_ready,

    input  logic [255:0]     dma_data,
    input  logic             dma_startofpacket,
    input  logic             dma_endofpacket,
    input  logic [1:0]       dma_empty,
    input  logic             dma_valid,
    output logic             dma_ready,

    output logic [255:0]     tx_st_data,
    output logic             tx_st_startofpacket,
    output logic             tx_st_endofpacket,
    output logic [1:0]       tx_st_empty,
    output logic             tx_st_error,
    output logic             tx_st_valid,
    input  logic             tx_st_ready,

    output logic [1:0]       grant,
    output logic             sop_err,
    output logic [CNT_W-1:0] cpl_pkt_cnt,
    output logic [CNT_W-1:0] dma_pkt_cnt
);

    localparam logic [1:0] ST_IDLE = ARB_IDLE;
    localparam logic [1:0] ST_CPL  = ARB_CPL;
    localparam logic [1:0] ST_DMA  = ARB_DMA;

    localparam int                 BURST_W     = 4;
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(CPL_BURST_MAX);

    logic [1:0]         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               dma_wait_q, dma_wait_d;
    logic               sop_err_q, sop_err_d;
    logic [CNT_W-1:0]   cpl_cnt_q, cpl_cnt_d;
    logic [CNT_W-1:0]   dma_cnt_q, dma_cnt_d;

    logic      room;
    logic      cpl_sop_v, dma_sop_v;
    logic      cpl_win, dma_win;
    logic      cpl_ready_c, dma_ready_c;
    logic      fwd_valid, fwd_dma, drop;
    logic      push, fwd_acc;
    logic      cpl_sop_acc, cpl_eop_acc, dma_eop_acc;
    logic      cpl_dma_waiting;
    tlp_beat_t beat_in, beat_out;
    logic [TLP_BEAT_W-1:0] skid_out;

    assign cpl_sop_v = cpl_valid & cpl_startofpacket;
    assign dma_sop_v = dma_valid & dma_startofpacket;

    always_comb begin
        state_d     = state_q;
        cpl_win     = 1'b0;
        dma_win     = 1'b0;
        cpl_ready_c = 1'b0;
        dma_ready_c = 1'b0;
        fwd_valid   = 1'b0;
        fwd_dma     = 1'b0;
        drop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpl_win = cpl_sop_v & ~((burst_q == BURST_LIMIT) & dma_sop_v);
                dma_win = ~cpl_win & dma_sop_v;
                if (cpl_win) begin
                    cpl_ready_c = room;
                    fwd_valid   = 1'b1;
                    if (room && !cpl_endofpacket) state_d = ST_CPL;
                end else if (cpl_valid && !cpl_startofpacket) begin
                    cpl_ready_c = 1'b1;
                    drop        = 1'b1;
                end
                if (dma_win) begin
                    dma_ready_c = room;
                    fwd_valid   = 1'b1;
                    fwd_dma     = 1'b1;
                    if (room && !dma_endofpacket) state_d = ST_DMA;
                end else if (dma_valid && !dma_startofpacket) begin
                    dma_ready_c = 1'b1;
                    drop        = 1'b1;
                end
            end
            ST_CPL: begin
                cpl_ready_c = room;
                fwd_valid   = cpl_valid;
                if (cpl_valid && room && cpl_endofpacket) state_d = ST_IDLE;
            end
            ST_DMA: begin
                dma_ready_c = room;
                fwd_valid   = dma_valid;
                fwd_dma     = 1'b1;
                if (dma_valid && room && dma_endofpacket) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Nothing is accepted while reset is held, so a partial packet cannot leak out.
    assign cpl_ready = cpl_ready_c & ~reset;
    assign dma_ready = dma_ready_c & ~reset;
    assign push      = fwd_valid & ~reset;
    assign fwd_acc   = push & room;

    assign cpl_sop_acc = fwd_acc & ~fwd_dma & (state_q == ST_IDLE);
    assign cpl_eop_acc = fwd_acc & ~fwd_dma & cpl_endofpacket;
    assign dma_eop_acc = fwd_acc &  fwd_dma & dma_endofpacket;

    // A single-beat completion starts and ends in IDLE, so sample dma_valid live.
    assign cpl_dma_waiting = (state_q == ST_IDLE) ? dma_valid : dma_wait_q;

    always_comb begin
        burst_d    = burst_q;
        dma_wait_d = dma_wait_q;
        sop_err_d  = sop_err_q | (drop & ~reset);
        cpl_cnt_d  = cpl_cnt_q;
        dma_cnt_d  = dma_cnt_q;
        if (cpl_sop_acc) dma_wait_d = dma_valid;
        if (cpl_eop_acc) begin
            cpl_cnt_d = cpl_cnt_q + CNT_W'(1);
            if (!cpl_dma_waiting)            burst_d = '0;
            else if (burst_q != BURST_LIMIT) burst_d = burst_q + BURST_W'(1);
        end
        if (dma_eop_acc) begin
            dma_cnt_d = dma_cnt_q + CNT_W'(1);
            burst_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            burst_q    <= '0;
            dma_wait_q <= 1'b0;
            sop_err_q  <= 1'b0;
            cpl_cnt_q  <= '0;
            dma_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            dma_wait_q <= dma_wait_d;
            sop_err_q  <= sop_err_d;
            cpl_cnt_q  <= cpl_cnt_d;
            dma_cnt_q  <= dma_cnt_d;
        end
    end

    assign beat_in = fwd_dma
        ? make_beat(dma_data, dma_startofpacket, dma_endofpacket, dma_empty)
        : make_beat(cpl_data, cpl_startofpacket, cpl_endofpacket, cpl_empty);

    fejkon_st_skid2 #(
        .W (TLP_BEAT_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (beat_in),
        .in_valid  (push),
        .in_ready  (room),
        .out_data  (skid_out),
        .out_valid (tx_st_valid),
        .out_ready (tx_st_ready)
    );

    assign beat_out            = skid_out;
    assign tx_st_data          = beat_out.data;
    assign tx_st_startofpacket = beat_out.sop;
    assign tx_st_endofpacket   = beat_out.eop;
    assign tx_st_empty         = beat_out.empty;
    assign tx_st_error         = 1'b0;

    assign grant       = state_q;
    assign sop_err     = sop_err_q;
    assign cpl_pkt_cnt = cpl_cnt_q;
    assign dma_pkt_cnt = dma_cnt_q;

endmodule

// File: tb/tb_fejkon_pcie_tx_arb.sv
// Self-checking bench for fejkon_pcie_tx_arb: a packet-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fejkon_pcie_tx_arb;
    import fejkon_pcie_pkg::*;

    localparam int BURST_MAX = 4;
    localparam int CNT_W     = 32;

    logic         clk;
    logic         reset;
    logic [255:0] cpl_data, dma_data, tx_st_data;
    logic         cpl_startofpacket, cpl_endofpacket, cpl_valid, cpl_ready;
    logic         dma_startofpacket, dma_endofpacket, dma_valid, dma_ready;
    logic [1:0]   cpl_empty, dma_empty, tx_st_empty;
    logic         tx_st_startofpacket, tx_st_endofpacket, tx_st_error, tx_st_valid, tx_st_ready;
    logic [1:0]   grant;
    logic         sop_err;
    logic [CNT_W-1:0] cpl_pkt_cnt, dma_pkt_cnt;

    fejkon_pcie_tx_arb #(
        .CPL_BURST_MAX (BURST_MAX),
        .CNT_W         (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cpl_data            (cpl_data),
        .cpl_startofpacket   (cpl_startofpacket),
        .cpl_endofpacket     (cpl_endofpacket),
        .cpl_empty           (cpl_empty),
        .cpl_valid           (cpl_valid),
        .cpl_ready           (cpl_ready),
        .dma_data            (dma_data),
        .dma_startofpacket   (dma_startofpacket),
        .dma_endofpacket     (dma_endofpacket),
        .dma_empty           (dma_empty),
        .dma_valid           (dma_valid),
        .dma_ready           (dma_ready),
        .tx_st_data          (tx_st_data),
        .tx_st_startofpacket (tx_st_startofpacket),
        .tx_st_endofpacket   (tx_st_endofpacket),
        .tx_st_empty         (tx_st_empty),
        .tx_st_error         (tx_st_error),
        .tx_st_valid         (tx_st_valid),
        .tx_st_ready         (tx_st_ready),
        .grant               (grant),
        .sop_err             (sop_err),
        .cpl_pkt_cnt         (cpl_pkt_cnt),
        .dma_pkt_cnt         (dma_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: beats owed to tx_st, packet owner, burst credit, counts.
    tlp_beat_t   exp_q[$];
    int          owner = 0;
    int          burst = 0;
    bit          cpl_wait = 1'b0;
    int unsigned m_cpl_cnt = 0;
    int unsigned m_dma_cnt = 0;
    bit          m_sop_err = 1'b0;
    logic [31:0] out_log[$];
    int          dma_stall = 0;

    task automatic model_accept(input int src, input int own0, input tlp_beat_t b, input bit dma_pending);
        if (own0 == 0 && !b.sop) begin
            m_sop_err = 1'b1;
            return;
        end
        exp_q.push_back(b);
        if (own0 == 0 && src == 1) cpl_wait = dma_pending;
        if (b.eop) begin
            if (src == 1) begin
                m_cpl_cnt++;
                burst = !cpl_wait ? 0 : (burst < BURST_MAX ? burst + 1 : BURST_MAX);
            end else begin
                m_dma_cnt++;
                burst = 0;
            end
            owner = 0;
        end else begin
            owner = src;
        end
    endtask

    always @(negedge clk) begin : monitor
        bit room, cw, dw, ecr, edr;
        int own0;
        if (reset) begin
            check("cpl_ready_in_reset", cpl_ready, 0);
            check("dma_ready_in_reset", dma_ready, 0);
            exp_q.delete();
            owner = 0; burst = 0; cpl_wait = 1'b0;
            m_cpl_cnt = 0; m_dma_cnt = 0; m_sop_err = 1'b0;
        end else begin
            check("tx_valid", tx_st_valid, exp_q.size() != 0);
            if (tx_st_valid && exp_q.size() != 0)
                check("tx_beat", {tx_st_data, tx_st_startofpacket, tx_st_endofpacket, tx_st_empty}, exp_q[0]);
            check("tx_error", tx_st_error, 0);
            check("grant", grant, owner);
            check("sop_err", sop_err, m_sop_err);
            check("cpl_pkt_cnt", cpl_pkt_cnt, m_cpl_cnt);
            check("dma_pkt_cnt", dma_pkt_cnt, m_dma_cnt);

            room = exp_q.size() < 2;
            if (owner == 0) begin
                cw  = cpl_valid && cpl_startofpacket &&
                      !(burst == BURST_MAX && dma_valid && dma_startofpacket);
                dw  = !cw && dma_valid && dma_startofpacket;
                ecr = cw ? room : (cpl_valid && !cpl_startofpacket);
                edr = dw ? room : (dma_valid && !dma_startofpacket);
            end else begin
                ecr = (owner == 1) && room;
                edr = (owner == 2) && room;
            end
            check("cpl_ready", cpl_ready, ecr);
            check("dma_ready", dma_ready, edr);
            if (dma_valid && !dma_ready) dma_stall++;

            if (tx_st_valid && tx_st_ready) begin
                if (tx_st_startofpacket) out_log.push_back(tx_st_data[31:0]);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            own0 = owner;
            if (cpl_valid && ecr)
                model_accept(1, own0, make_beat(cpl_data, cpl_startofpacket, cpl_endofpacket, cpl_empty), dma_valid);
            if (dma_valid && edr)
                model_accept(2, own0, make_beat(dma_data, dma_startofpacket, dma_endofpacket, dma_empty), dma_valid);
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic [31:0] tag, input int b, input int nbeats, input bit bad_sop);
        logic [255:0] d;
        logic         s, e;
        logic [1:0]   em;
        d  = {8{tag + 32'(b)}};
        s  = (b == 0) && !bad_sop;
        e  = (b == nbeats - 1);
        em = e ? tag[1:0] : 2'b00;
        if (src == 1) begin
            cpl_data = d; cpl_startofpacket = s; cpl_endofpacket = e; cpl_empty = em; cpl_valid = 1'b1;
        end else begin
            dma_data = d; dma_startofpacket = s; dma_endofpacket = e; dma_empty = em; dma_valid = 1'b1;
        end
    endtask

    task automatic send_pkt(input int src, input logic [31:0] tag, input int nbeats, input bit bad_sop = 1'b0);
        bit acc;
        for (int b = 0; b < nbeats; b++) begin
            drive(src, tag, b, nbeats, bad_sop);
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = (src == 1) ? cpl_ready : dma_ready;
                sync();
            end
            if (!acc) check("send_timeout", acc, 1);
        end
        if (src == 1) begin cpl_valid = 1'b0; cpl_startofpacket = 1'b0; end
        else          begin dma_valid = 1'b0; dma_startofpacket = 1'b0; end
    endtask

    task automatic check_order(input string name, input logic [31:0] exp[$]);
        check({name, "_len"}, out_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < out_log.size()) check(name, out_log[i], exp[i]);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] e[$];
        reset = 1'b1; tx_st_ready = 1'b1;
        cpl_data = '0; cpl_startofpacket = 0; cpl_endofpacket = 0; cpl_empty = 0; cpl_valid = 0;
        dma_data = '0; dma_startofpacket = 0; dma_endofpacket = 0; dma_empty = 0; dma_valid = 0;
        repeat (3) sync();
        reset = 1'b0;
        @(negedge clk);
        check("rst_tx_valid", tx_st_valid, 0);
        check("rst_grant", grant, 2'b00);
        check("rst_counts", {cpl_pkt_cnt, dma_pkt_cnt}, 0);

        // 1: single-beat completion, forwarded one cycle after acceptance
        sync();
        send_pkt(1, 32'h4A00_0001, 1);
        @(negedge clk);
        check("t1_tx_valid_n1", tx_st_valid, 1);
        check("t1_tx_dw0_n1", tx_st_data[31:0], 32'h4A00_0001);
        repeat (2) sync();
        check("t1_cpl_cnt", cpl_pkt_cnt, 1);
        check("t1_grant", grant, 2'b00);

        // 2: simultaneous SOP, completion first, DMA stalls exactly one cycle
        out_log.delete(); dma_stall = 0;
        fork
            send_pkt(2, 32'hD200_0000, 3);
            send_pkt(1, 32'hC200_0000, 1);
        join
        repeat (3) sync();
        e = '{32'hC200_0000, 32'hD200_0000};
        check_order("t2_order", e);
        check("t2_dma_stall", dma_stall, 1);
        check("t2_dma_cnt", dma_pkt_cnt, 1);

        // 3: burst limit lets DMA through after four completions
        out_log.delete();
        fork
            for (int i = 0; i < 6; i++) send_pkt(1, 32'hC300_0000 + 32'(i << 8), 1);
            send_pkt(2, 32'hD300_0000, 2);
        join
        repeat (3) sync();
        e = '{32'hC300_0000, 32'hC300_0100, 32'hC300_0200, 32'hC300_0300,
              32'hD300_0000, 32'hC300_0400, 32'hC300_0500};
        check_order("t3_order", e);
        check("t3_cpl_cnt", cpl_pkt_cnt, 8);

        // 4: back-pressure fills the skid; completion waits for the DMA EOP
        out_log.delete(); dma_stall = 0;
        fork
            send_pkt(2, 32'hD400_0000, 4);
            begin
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (dma_valid && dma_ready && dma_startofpacket) break;
                end
                sync();
                tx_st_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 tx_st_ready = 1'b1;
            end
            begin
                repeat (3) sync();
                send_pkt(1, 32'hC400_0000, 1);
            end
        join
        repeat (4) sync();
        e = '{32'hD400_0000, 32'hC400_0000};
        check_order("t4_order", e);
        check("t4_dma_stall", dma_stall, 5);
        check("t4_dma_cnt", dma_pkt_cnt, 3);

        // 5: non-SOP beat in IDLE is dropped and flagged
        out_log.delete();
        send_pkt(1, 32'hBAD0_0000, 1, 1'b1);
        repeat (2) sync();
        check("t5_sop_err", sop_err, 1);
        send_pkt(1, 32'hC500_0000, 1);
        repeat (2) sync();
        e = '{32'hC500_0000};
        check_order("t5_order", e);
        check("t5_sop_err_sticky", sop_err, 1);
        check("t5_cpl_cnt", cpl_pkt_cnt, 10);

        // 6: reset with a partial DMA packet inside the skid
        tx_st_ready = 1'b0;
        drive(2, 32'hD600_0000, 0, 3, 1'b0);
        sync();
        drive(2, 32'hD600_0000, 1, 3, 1'b0);
        sync();
        drive(2, 32'hD600_0000, 2, 3, 1'b0);
        reset = 1'b1;
        sync();
        reset = 1'b0; dma_valid = 1'b0; dma_startofpacket = 1'b0;
        @(negedge clk);
        check("t6_tx_valid", tx_st_valid, 0);
        check("t6_grant", grant, 2'b00);
        check("t6_counts", {cpl_pkt_cnt, dma_pkt_cnt}, 0);
        check("t6_sop_err", sop_err, 0);
        sync();
        tx_st_ready = 1'b1;
        out_log.delete();
        send_pkt(2, 32'hD6F0_0000, 2);
        repeat (3) sync();
        e = '{32'hD6F0_0000};
        check_order("t6_order", e);
        check("t6_dma_cnt", dma_pkt_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
